// File: rtl/weekday_pkg.sv
// ---------------------------------------------------------------------------
// weekday_pkg
// Shared definitions for the weekday controller and the LED selector stage:
//   - one-hot weekday constants (bit 0 = MON ... bit 6 = SUN)
//   - RUN/SET controller state encoding
//   - rotl7: advance a one-hot weekday by one day (SUN wraps to MON)
// ---------------------------------------------------------------------------
package weekday_pkg;

   localparam logic [6:0] DAY_MON = 7'b0000001;
   localparam logic [6:0] DAY_TUE = 7'b0000010;
   localparam logic [6:0] DAY_WED = 7'b0000100;
   localparam logic [6:0] DAY_THU = 7'b0001000;
   localparam logic [6:0] DAY_FRI = 7'b0010000;
   localparam logic [6:0] DAY_SAT = 7'b0100000;
   localparam logic [6:0] DAY_SUN = 7'b1000000;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_e;

   function automatic logic [6:0] rotl7(input logic [6:0] d);
      return {d[5:0], d[6]};
   endfunction

endpackage

// File: rtl/blink_gen.sv
// ---------------------------------------------------------------------------
// blink_gen
// Square-wave generator for the set-mode blink.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   en    in  enable; low clears the counter and forces pulse low
//   pulse out registered square wave, high for the first BLINK_HALF cycles
//             after en rises, then toggling every BLINK_HALF cycles
// ---------------------------------------------------------------------------
module blink_gen #(
   parameter int unsigned BLINK_HALF = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic pulse
);

   localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;
   logic          en_q;

   always_comb begin
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      if (!en) begin
         cnt_d   = '0;
         pulse_d = 1'b0;
      end else if (!en_q) begin
         // first enabled cycle starts the high phase
         cnt_d   = '0;
         pulse_d = 1'b1;
      end else if (cnt_q == CW'(BLINK_HALF - 1)) begin
         cnt_d   = '0;
         pulse_d = ~pulse_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         en_q    <= en;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/weekday_ctrl.sv
// ---------------------------------------------------------------------------
// weekday_ctrl
// Current-weekday register with a set mode for choosing a new weekday.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   day_tick in   one-cycle pulse at midnight; advances w in RUN and SET
//   mode_btn in   enter set mode (RUN) / commit candidate (SET)
//   inc_btn  in   advance the candidate weekday (SET only)
//   w        out  current weekday, one-hot
//   iw       out  candidate weekday, one-hot
//   wset     out  high while in set mode
//   pulse    out  blink wave for the candidate display
// Set mode auto-aborts after SET_TIMEOUT cycles without a button press.
// ---------------------------------------------------------------------------
module weekday_ctrl
   import weekday_pkg::*;
#(
   parameter int unsigned BLINK_HALF  = 25_000_000,
   parameter int unsigned SET_TIMEOUT = 500_000_000,
   parameter logic [6:0]  RESET_DAY   = DAY_MON
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       day_tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [6:0] w,
   output logic [6:0] iw,
   output logic       wset,
   output logic       pulse
);

   localparam int unsigned TW = (SET_TIMEOUT > 1) ? $clog2(SET_TIMEOUT) : 1;

   state_e        state_q, state_d;
   logic [6:0]    w_q, w_d;
   logic [6:0]    iw_q, iw_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [6:0]    w_tick;
   logic [6:0]    iw_inc;

   always_comb begin
      w_tick  = day_tick ? rotl7(w_q) : w_q;
      iw_inc  = inc_btn ? rotl7(iw_q) : iw_q;
      state_d = state_q;
      w_d     = w_tick;
      iw_d    = iw_q;
      tcnt_d  = tcnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (mode_btn) begin
               state_d = ST_SET;
               iw_d    = w_tick;
               tcnt_d  = '0;
            end
         end
         ST_SET: begin
            iw_d = iw_inc;
            if (mode_btn) begin
               // commit wins over a same-cycle day_tick
               w_d     = iw_inc;
               state_d = ST_RUN;
               tcnt_d  = '0;
            end else if (inc_btn) begin
               tcnt_d = '0;
            end else if (tcnt_q == TW'(SET_TIMEOUT - 1)) begin
               state_d = ST_RUN;
               tcnt_d  = '0;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         w_q     <= RESET_DAY;
         iw_q    <= RESET_DAY;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         iw_q    <= iw_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Driven from the next state so pulse rises and falls on the same edge
   // as wset.
   blink_gen #(
      .BLINK_HALF(BLINK_HALF)
   ) u_blink (
      .clk  (clk),
      .rst  (rst),
      .en   (state_d == ST_SET),
      .pulse(pulse)
   );

   assign w    = w_q;
   assign iw   = iw_q;
   assign wset = (state_q == ST_SET);

endmodule

// File: tb/tb_weekday_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weekday_ctrl
// Scoreboard bench: each driven cycle pushes the expected outputs computed by
// a day-index / cycle-count reference model; a monitor pops one entry per
// cycle on the falling edge and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_weekday_ctrl;

   localparam int unsigned BH = 4;
   localparam int unsigned TO = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       day_tick = 1'b0;
   logic       mode_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [6:0] w, iw;
   logic       wset, pulse;

   always #5 clk = ~clk;

   weekday_ctrl #(
      .BLINK_HALF (BH),
      .SET_TIMEOUT(TO),
      .RESET_DAY  (7'b0000001)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .day_tick(day_tick),
      .mode_btn(mode_btn),
      .inc_btn (inc_btn),
      .w       (w),
      .iw      (iw),
      .wset    (wset),
      .pulse   (pulse)
   );

   typedef struct {
      logic [6:0] w;
      logic [6:0] iw;
      logic       wset;
      logic       pulse;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model: weekday as index 0..6, time as absolute cycle numbers
   int     m_day  = 0;
   int     m_cand = 0;
   bit     m_set  = 1'b0;
   longint cyc = 0, entry_cyc = 0, clear_cyc = 0;

   function automatic logic [6:0] onehot(input int idx);
      logic [6:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic model_step(input bit r, input bit t, input bit m, input bit i);
      int   nday, ncand;
      exp_t e;
      cyc++;
      if (r) begin
         m_day  = 0;
         m_cand = 0;
         m_set  = 1'b0;
      end else if (!m_set) begin
         if (t) m_day = (m_day + 1) % 7;
         if (m) begin
            m_set     = 1'b1;
            m_cand    = m_day;
            entry_cyc = cyc;
            clear_cyc = cyc;
         end
      end else begin
         nday   = t ? (m_day + 1) % 7 : m_day;
         ncand  = i ? (m_cand + 1) % 7 : m_cand;
         m_cand = ncand;
         if (m) begin
            m_day = ncand;
            m_set = 1'b0;
         end else begin
            m_day = nday;
            if (i) clear_cyc = cyc;
            else if (cyc - clear_cyc == longint'(TO)) m_set = 1'b0;
         end
      end
      e.w     = onehot(m_day);
      e.iw    = onehot(m_cand);
      e.wset  = m_set;
      e.pulse = m_set && (((cyc - entry_cyc) / BH) % 2 == 0);
      sb.push_back(e);
   endtask

   task automatic drive(input bit r, input bit t, input bit m, input bit i);
      @(negedge clk);
      rst      = r;
      day_tick = t;
      mode_btn = m;
      inc_btn  = i;
      @(posedge clk);
      #1;
      model_step(r, t, m, i);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp_v, $time);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("w", w, e.w);
         chk("iw", iw, e.iw);
         chk("wset", 7'(wset), 7'(e.wset));
         chk("pulse", 7'(pulse), 7'(e.pulse));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p_inc;
      // reset
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      // full week of ticks, back to MON
      for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
      // advance to FRI, set SAT/SUN/MON, commit
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      // idle timeout with blink observed throughout
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      idle(25);
      // day_tick while in set mode, then commit
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      // candidate WED, then mode+inc+tick together commits THU
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 7 && m_cand != 2; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);
      // reset in the middle of set mode with iw != w
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      // randomized traffic; inc rate alternates so timeouts also occur
      for (int blk = 0; blk < 15; blk++) begin
         p_inc = (blk % 2 == 0) ? 4 : 40;
         for (int k = 0; k < 200; k++) begin
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, p_inc - 1) == 0);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weekday_ctrl.md
# weekday_ctrl

Weekday register and set-mode controller that feeds the LED selector stage. It advances the current weekday on each day-rollover tick and runs a set mode in which the user rotates a candidate weekday with a button, then commits or abandons it. It also produces the blink pulse that the LED stage gates onto the candidate display.

## Interface
Parameters:
- `BLINK_HALF`, default 25_000_000: clock cycles per blink half-period; must be ≥ 1.
- `SET_TIMEOUT`, default 500_000_000: idle cycles in set mode before it auto-aborts; must be ≥ 1.
- `RESET_DAY`, default 7'b0000001 (MON): weekday loaded at reset; must be one-hot.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: reset, synchronous and active-high.
- `day_tick`, in, 1: one-cycle pulse from the time-of-day counter at 23:59:59→00:00:00.
- `mode_btn`, in, 1: debounced one-cycle pulse. Enters set mode, or commits when already in set mode.
- `inc_btn`, in, 1: debounced one-cycle pulse. Rotates the candidate weekday.
- `w`, out, 7: current weekday, one-hot. Bit 0 = MON … bit 6 = SUN.
- `iw`, out, 7: candidate weekday in set mode, one-hot.
- `wset`, out, 1: high while in set mode.
- `pulse`, out, 1: blink square wave; meaningful only while `wset` = 1.

## Operation
- There are two states, RUN and SET. All outputs are registered.
- Reset values:
  - `w` = `RESET_DAY`, `iw` = `RESET_DAY`
  - `wset` = 0, `pulse` = 0
  - state = RUN; blink counter and timeout counter = 0
- Weekday rotation is a rotate-left by 1. Bit 6 wraps to bit 0 (SUN→MON).
- `w` rotates on every `day_tick`, in both RUN and SET.
- RUN state:
  - `mode_btn` → go to SET.
  - On entry to SET: `iw` ← `w`, but if a `day_tick` arrives in the same cycle, `iw` takes the rotated `w`.
  - On entry to SET: `wset` = 1, `pulse` = 1, blink counter = 0, timeout counter = 0.
  - `inc_btn` is ignored in RUN. `iw` holds its last value.
- SET state:
  - `inc_btn` → `iw` rotates and the timeout counter clears.
  - `mode_btn` → commit: `w` ← `iw`, then go to RUN. The commit overrides any `day_tick` in the same cycle, so `w` = `iw` exactly.
  - If `mode_btn` and `inc_btn` arrive in the same cycle, the commit takes the already-rotated `iw`.
  - Timeout counter reaches `SET_TIMEOUT`−1 with no button press → abort: go to RUN, `w` is unchanged (a `day_tick` in that cycle still applies).
  - A button press in the same cycle as the timeout takes priority over the abort.
  - Blink: `pulse` toggles whenever the blink counter reaches `BLINK_HALF`−1; the counter then wraps to 0.
- On returning to RUN: `wset` = 0 and `pulse` = 0 in the same registered update.
- `rst` asserted mid-SET: the block returns to reset values on the next edge and nothing is committed.
- Non-one-hot state is unreachable; no recovery logic is required.

## Timing
- Input pulse sampled at edge N → outputs reflect it after edge N (one-cycle latency).
- `pulse` period in SET is 2·`BLINK_HALF` cycles. The first high phase lasts `BLINK_HALF` cycles, counted from the entry edge.
- Abort occurs exactly `SET_TIMEOUT` cycles after the last counter clear (SET entry or last `inc_btn`).
- Inputs are single-cycle pulses. A level held high is treated as one press per cycle.

## Structure
- Shared package `weekday_pkg` holds:
  - one-hot day constants `DAY_MON` … `DAY_SUN`
  - the RUN/SET state encoding
  - a `rotl7` function
- The LED selector stage also uses `weekday_pkg`.
- Sub-module `blink_gen` (params `BLINK_HALF`; ports `clk`, `rst`, `en`, `pulse`):
  - `en` low → counter cleared and `pulse` low
  - rising `en` → `pulse` high
- Timeout counter width is `$clog2(SET_TIMEOUT)`; blink counter width is `$clog2(BLINK_HALF)`.

## Test plan
Use `BLINK_HALF` = 4 and `SET_TIMEOUT` = 20 for all scenarios.
1. Reset, then 7 `day_tick` pulses → `w` steps MON, TUE, … SUN, then back to MON; `wset` stays 0.
2. `w` = FRI (7'b0010000); `mode_btn`, then `inc_btn` ×3, then `mode_btn` → `iw` goes SAT, SUN, MON; `w` = MON after the commit; `wset` falls.
3. In SET, no buttons for 20 cycles → abort on cycle 20, `w` unchanged. In SET, `day_tick` → `w` advances, `iw` unchanged.
4. Enter SET → `pulse` runs 1111000011110000…; it drops to 0 the cycle after exiting SET.
5. In SET, `mode_btn` + `inc_btn` + `day_tick` in the same cycle, with `iw` = WED → `w` = THU, RUN state.
6. `rst` asserted mid-SET with `iw` ≠ `w` → `w` = `iw` = MON, `wset` = 0, `pulse` = 0 on the next cycle.
